// File: rtl/fir_stream_sequencer.sv
// Streams int32 samples from memory through an external FIR filter and
// writes each result back over one Avalon-MM master, one sample at a time.
module fir_stream_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [ADDR_W-1:0] cmd_dst_base,
  output logic              status_busy,
  output logic              status_done,
  output logic [LEN_W-1:0]  status_count,
  output logic              master_read,
  output logic              master_write,
  output logic [ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0] master_writedata,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_waitrequest,
  output logic [3:0]        master_byteen,
  output logic              filt_clr,
  output logic              filt_en,
  output logic [DATA_W-1:0] filt_in,
  input  logic [DATA_W-1:0] filt_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    FEED  = 3'd3,
    CAPT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Every output and internal register lives in one bundle so the
  // whole machine resets and updates as a unit.
  typedef struct packed {
    state_t              state;
    logic                rd;
    logic                wr;
    logic                clr;
    logic                en;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   fin;
    logic [LEN_W-1:0]    count;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    len;
  } regs_t;

  regs_t r;
  regs_t n;

  logic [LEN_W-1:0] idx_nx;

  function automatic logic [ADDR_W-1:0] word_off(
    input logic [LEN_W-1:0] i
  );
    return ADDR_W'({i, 2'b00});
  endfunction

  assign idx_nx = r.idx + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) r <= '0;
    else        r <= n;
  end

  always_comb begin
    n     = r;
    n.clr = 1'b0;
    n.en  = 1'b0;
    unique case (r.state)
      IDLE: begin
        if (cmd_start) begin
          n.len   = cmd_len;
          n.src   = cmd_src_base;
          n.dst   = cmd_dst_base;
          n.idx   = '0;
          n.count = '0;
          if (cmd_len == '0) begin
            n.state = DONE;
            n.done  = 1'b1;
          end else begin
            n.state = CLEAR;
            n.clr   = 1'b1;
            n.busy  = 1'b1;
          end
        end
      end
      CLEAR: begin
        n.rd    = 1'b1;
        n.addr  = r.src;
        n.state = READ;
      end
      READ: begin
        if (!master_waitrequest) begin
          n.fin   = master_readdata;
          n.rd    = 1'b0;
          n.en    = 1'b1;
          n.state = FEED;
        end
      end
      FEED: n.state = CAPT;
      CAPT: begin
        n.wdata = filt_out;
        n.wr    = 1'b1;
        n.addr  = r.dst + word_off(r.idx);
        n.state = WRITE;
      end
      WRITE: begin
        if (!master_waitrequest) begin
          n.wr    = 1'b0;
          n.count = idx_nx;
          if (idx_nx == r.len) begin
            n.state = DONE;
            n.busy  = 1'b0;
            n.done  = 1'b1;
          end else begin
            n.idx   = idx_nx;
            n.rd    = 1'b1;
            n.addr  = r.src + word_off(idx_nx);
            n.state = READ;
          end
        end
      end
      DONE: begin
        if (!cmd_start) begin
          n.done  = 1'b0;
          n.state = IDLE;
        end
      end
      default: n = '0;
    endcase
  end

  assign status_busy      = r.busy;
  assign status_done      = r.done;
  assign status_count     = r.count;
  assign master_read      = r.rd;
  assign master_write     = r.wr;
  assign master_address   = r.addr;
  assign master_writedata = r.wdata;
  assign master_byteen    = 4'b1111;
  assign filt_clr         = r.clr;
  assign filt_en          = r.en;
  assign filt_in          = r.fin;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: memory slave with scripted stalls,
// stub filter (out = in + 100) and a queue-based reference model.
module tb_fir_stream_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_start;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_src_base;
  logic [AW-1:0] cmd_dst_base;
  logic          status_busy;
  logic          status_done;
  logic [LW-1:0] status_count;
  logic          master_read;
  logic          master_write;
  logic [AW-1:0] master_address;
  logic [DW-1:0] master_writedata;
  logic [DW-1:0] master_readdata;
  logic          wreq = 1'b0;
  logic [3:0]    master_byteen;
  logic          filt_clr;
  logic          filt_en;
  logic [DW-1:0] filt_in;
  logic [DW-1:0] fout = '0;

  always #5 clk = ~clk;

  fir_stream_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
    .status_busy(status_busy), .status_done(status_done),
    .status_count(status_count),
    .master_read(master_read), .master_write(master_write),
    .master_address(master_address),
    .master_writedata(master_writedata),
    .master_readdata(master_readdata),
    .master_waitrequest(wreq),
    .master_byteen(master_byteen),
    .filt_clr(filt_clr), .filt_en(filt_en),
    .filt_in(filt_in), .filt_out(fout)
  );

  logic [DW-1:0] mem [0:1023];
  assign master_readdata = mem[master_address];

  always @(posedge clk) if (filt_en) fout <= filt_in + 32'd100;

  int checks = 0;
  int failures = 0;

  int rd_stall [16];
  int wr_stall [16];

  logic [AW-1:0] rd_q [$];
  logic [AW-1:0] wr_q [$];
  logic [DW-1:0] wd_q [$];
  int clr_tot = 0, en_tot = 0, busy_tot = 0;
  int both_err = 0, stab_err = 0;
  int rd_blk = 0, wr_blk = 0, used = 0;
  logic pv_wait = 0, pv_rd = 0, pv_wr = 0;
  logic [AW-1:0] pv_addr = '0;
  logic [DW-1:0] pv_data = '0;

  // Slave: decides each cycle's waitrequest at the falling edge and
  // logs a transfer when it is allowed to complete at the next rise.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      rd_blk = 0; wr_blk = 0; used = 0;
      wreq = 1'b0; pv_wait = 1'b0; pv_rd = 1'b0; pv_wr = 1'b0;
    end else begin
      if (filt_clr) begin
        rd_blk = 0; wr_blk = 0; used = 0;
        clr_tot++;
      end
      if (filt_en) en_tot++;
      if (status_busy) busy_tot++;
      if (master_read && master_write) both_err++;
      if (pv_wait && pv_rd &&
          (master_read !== 1'b1 || master_address !== pv_addr))
        stab_err++;
      if (pv_wait && pv_wr &&
          (master_write !== 1'b1 || master_address !== pv_addr ||
           master_writedata !== pv_data))
        stab_err++;
      pv_rd = master_read;
      pv_wr = master_write;
      pv_addr = master_address;
      pv_data = master_writedata;
      if (master_read) begin
        if (used < rd_stall[rd_blk & 15]) begin
          wreq = 1'b1; used++;
        end else begin
          wreq = 1'b0; used = 0;
          rd_q.push_back(master_address);
          rd_blk++;
        end
      end else if (master_write) begin
        if (used < wr_stall[wr_blk & 15]) begin
          wreq = 1'b1; used++;
        end else begin
          wreq = 1'b0; used = 0;
          wr_q.push_back(master_address);
          wd_q.push_back(master_writedata);
          wr_blk++;
        end
      end else begin
        wreq = 1'b0;
      end
      pv_wait = wreq;
    end
  end

  // Reference: sample i is read at src+4i and its result (value+100)
  // lands at dst+4i, both addresses wrapping at 1024 bytes.
  function automatic int log_diffs(int rb, int wb, int len,
                                   int src, int dst);
    int nd = 0;
    if (rd_q.size() != rb + len) nd++;
    if (wr_q.size() != wb + len) nd++;
    for (int i = 0; i < len; i++) begin
      int sa = (src + 4 * i) % 1024;
      int da = (dst + 4 * i) % 1024;
      if (rb + i < rd_q.size()) begin
        if (rd_q[rb + i] !== AW'(sa)) nd++;
      end else nd++;
      if (wb + i < wr_q.size()) begin
        if (wr_q[wb + i] !== AW'(da)) nd++;
        if (wd_q[wb + i] !== mem[sa] + 32'd100) nd++;
      end else nd++;
    end
    return nd;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) begin
      rd_stall[i] = 0;
      wr_stall[i] = 0;
    end
  endtask

  task automatic start_block(input int len, input int src, input int dst);
    @(posedge clk); #1;
    cmd_len = LW'(len);
    cmd_src_base = AW'(src);
    cmd_dst_base = AW'(dst);
    cmd_start = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (status_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_block();
    @(posedge clk); #1;
    cmd_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({master_read, master_write, filt_clr, filt_en,
         status_busy, status_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {master_read, master_write, filt_clr, filt_en,
                status_busy, status_done});
    end
    checks++;
    if (master_address !== '0 || master_writedata !== '0 ||
        filt_in !== '0 || status_count !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%0d wd=%0d fin=%0d cnt=%0d want=0",
               master_address, master_writedata, filt_in, status_count);
    end
    checks++;
    if (master_byteen !== 4'hf) begin
      failures++;
      $display("FAIL byteen got=%h want=f", master_byteen);
    end
  endtask

  task automatic test_zero_len();
    int rb = rd_q.size(), wb = wr_q.size(), eb = en_tot;
    start_block(0, 40, 80);
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({status_done, status_busy} !== 2'b10 || status_count !== '0) begin
      failures++;
      $display("FAIL zero_len_state got done=%b busy=%b cnt=%0d want 1 0 0",
               status_done, status_busy, status_count);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != rb || wr_q.size() != wb || en_tot != eb) begin
      failures++;
      $display("FAIL zero_len_bus got rd=%0d wr=%0d en=%0d want 0 0 0",
               rd_q.size() - rb, wr_q.size() - wb, en_tot - eb);
    end
    stop_block();
  endtask

  task automatic test_basic();
    int rb = rd_q.size(), wb = wr_q.size();
    int bb = busy_tot, eb = en_tot, cb = clr_tot, xb = both_err;
    int nd;
    bit ok;
    clear_stalls();
    for (int i = 0; i < 4; i++) mem[i] = DW'(i + 1);
    start_block(4, 0, 512);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL basic_timeout got done=0 want=1");
    end
    nd = log_diffs(rb, wb, 4, 0, 512);
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL basic_xfers got diffs=%0d want=0", nd);
    end
    checks++;
    if (busy_tot - bb != 17) begin
      failures++;
      $display("FAIL basic_cycles got=%0d want=17", busy_tot - bb);
    end
    checks++;
    if (en_tot - eb != 4 || clr_tot - cb != 1) begin
      failures++;
      $display("FAIL basic_pulses got en=%0d clr=%0d want 4 1",
               en_tot - eb, clr_tot - cb);
    end
    checks++;
    if (status_count !== LW'(4) || both_err != xb) begin
      failures++;
      $display("FAIL basic_count got cnt=%0d both=%0d want 4 0",
               status_count, both_err - xb);
    end
    stop_block();
  endtask

  task automatic test_stalls();
    int rb = rd_q.size(), wb = wr_q.size();
    int bb = busy_tot, sb = stab_err;
    int nd;
    bit ok;
    clear_stalls();
    rd_stall[1] = 3;
    wr_stall[2] = 2;
    start_block(4, 0, 512);
    wait_done(ok);
    nd = log_diffs(rb, wb, 4, 0, 512);
    checks++;
    if (ok !== 1'b1 || nd != 0) begin
      failures++;
      $display("FAIL stall_xfers got ok=%0d diffs=%0d want 1 0", ok, nd);
    end
    checks++;
    if (busy_tot - bb != 22) begin
      failures++;
      $display("FAIL stall_cycles got=%0d want=22", busy_tot - bb);
    end
    checks++;
    if (stab_err != sb) begin
      failures++;
      $display("FAIL stall_stable got=%0d want=0", stab_err - sb);
    end
    clear_stalls();
    stop_block();
  endtask

  task automatic test_wrap();
    int rb = rd_q.size(), wb = wr_q.size();
    int nd;
    bit ok;
    clear_stalls();
    start_block(3, 1016, 1022);
    wait_done(ok);
    nd = log_diffs(rb, wb, 3, 1016, 1022);
    checks++;
    if (ok !== 1'b1 || nd != 0) begin
      failures++;
      $display("FAIL wrap_xfers got ok=%0d diffs=%0d want 1 0", ok, nd);
    end
    checks++;
    if (rd_q.size() == rb + 3 && rd_q[rb + 2] !== AW'(0)) begin
      failures++;
      $display("FAIL wrap_third_read got=%0d want=0", rd_q[rb + 2]);
    end
    stop_block();
  endtask

  task automatic test_hold_restart();
    int rb, wb, hold = 0;
    int nd;
    bit ok;
    clear_stalls();
    start_block(3, 100, 300);
    wait_done(ok);
    rb = rd_q.size();
    cmd_len = LW'(7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (status_done === 1'b1 && status_busy === 1'b0) hold++;
    end
    checks++;
    if (hold != 10 || rd_q.size() != rb) begin
      failures++;
      $display("FAIL hold_done got done_cycles=%0d new_reads=%0d want 10 0",
               hold, rd_q.size() - rb);
    end
    stop_block();
    @(negedge clk); #1;
    checks++;
    if ({status_done, status_busy} !== 2'b00) begin
      failures++;
      $display("FAIL hold_idle got done=%b busy=%b want 0 0",
               status_done, status_busy);
    end
    rb = rd_q.size();
    wb = wr_q.size();
    start_block(2, 200, 600);
    wait_done(ok);
    nd = log_diffs(rb, wb, 2, 200, 600);
    checks++;
    if (ok !== 1'b1 || nd != 0 || status_count !== LW'(2)) begin
      failures++;
      $display("FAIL restart got ok=%0d diffs=%0d cnt=%0d want 1 0 2",
               ok, nd, status_count);
    end
    stop_block();
  endtask

  task automatic test_reset_mid();
    int rb, wb, cb;
    int nd;
    bit ok, hit = 0;
    clear_stalls();
    wr_stall[1] = 50;
    wb = wr_q.size();
    start_block(4, 20, 700);
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      if (master_write && wreq && wr_q.size() == wb + 1) hit = 1;
    end
    checks++;
    if (hit !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_reach got=0 want=1");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({master_read, master_write, filt_clr, filt_en,
         status_busy, status_done} !== 6'b0 ||
        master_address !== '0 || status_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got ctl=%b addr=%0d cnt=%0d want 0",
               {master_read, master_write, filt_clr, filt_en,
                status_busy, status_done}, master_address, status_count);
    end
    clear_stalls();
    rb = rd_q.size();
    wb = wr_q.size();
    cb = clr_tot;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done(ok);
    nd = log_diffs(rb, wb, 4, 20, 700);
    checks++;
    if (ok !== 1'b1 || nd != 0 || clr_tot - cb != 1) begin
      failures++;
      $display("FAIL rst_mid_fresh got ok=%0d diffs=%0d clr=%0d want 1 0 1",
               ok, nd, clr_tot - cb);
    end
    stop_block();
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 8);
      int src = $urandom_range(0, 1023);
      int dst = $urandom_range(0, 1023);
      int rb = rd_q.size(), wb = wr_q.size();
      int bb = busy_tot, eb = en_tot, xb = both_err, sb = stab_err;
      int want_busy = 1 + 4 * len;
      int nd;
      bit ok;
      clear_stalls();
      for (int i = 0; i < len; i++) begin
        rd_stall[i] = $urandom_range(0, 2);
        wr_stall[i] = $urandom_range(0, 2);
        want_busy += rd_stall[i] + wr_stall[i];
      end
      start_block(len, src, dst);
      wait_done(ok);
      nd = log_diffs(rb, wb, len, src, dst);
      checks++;
      if (ok !== 1'b1 || nd != 0) begin
        failures++;
        $display("FAIL rand%0d_xfers got ok=%0d diffs=%0d want 1 0",
                 b, ok, nd);
      end
      checks++;
      if (busy_tot - bb != want_busy || en_tot - eb != len ||
          status_count !== LW'(len)) begin
        failures++;
        $display("FAIL rand%0d_timing got busy=%0d en=%0d cnt=%0d want %0d %0d %0d",
                 b, busy_tot - bb, en_tot - eb, status_count,
                 want_busy, len, len);
      end
      checks++;
      if (both_err != xb || stab_err != sb) begin
        failures++;
        $display("FAIL rand%0d_bus got both=%0d unstable=%0d want 0 0",
                 b, both_err - xb, stab_err - sb);
      end
      stop_block();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    clear_stalls();
    rst_n = 1'b0;
    cmd_start = 1'b0;
    cmd_len = '0;
    cmd_src_base = '0;
    cmd_dst_base = '0;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_zero_len();
    test_basic();
    test_stalls();
    test_wrap();
    test_hold_restart();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_stream_sequencer.md
Name: fir_stream_sequencer

Overview:
- Streams a block of int32 samples through the FIR filter datapath over the Avalon-MM master port, one sample at a time: read sample, feed filter, capture result, write result.
- Replaces load-all-then-compute sequencing. No local sample memory is needed, and waitrequest is honoured on every transfer.
- Sits between the command/status ports and the filter instance; drives the filter's clear, enable and input.
- Base addresses and block length are configurable per command.

Parameters:
ADDR_W, 10, Avalon byte-address width
DATA_W, 32, sample/data width
LEN_W, 16, width of sample counter and length field

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cmd_start  input  1  level command; rising into IDLE starts a block, must drop to leave DONE
cmd_len  input  LEN_W  number of samples in block
cmd_src_base  input  ADDR_W  byte address of sample 0
cmd_dst_base  input  ADDR_W  byte address of result 0
status_busy  output  1  high in CLEAR..WRITE
status_done  output  1  high in DONE
status_count  output  LEN_W  samples completed (written) in current block
master_read  output  1  Avalon read request
master_write  output  1  Avalon write request
master_address  output  ADDR_W  Avalon byte address
master_writedata  output  DATA_W  Avalon write data
master_readdata  input  DATA_W  Avalon read data
master_waitrequest  input  1  Avalon stall
master_byteen  output  4  constant 4'b1111
filt_clr  output  1  one-cycle filter clear pulse
filt_en  output  1  one-cycle filter shift/update pulse
filt_in  output  DATA_W  sample presented to filter
filt_out  input  DATA_W  filter result; valid the cycle after filt_en

Behaviour:
- All outputs are registered.
- Reset: sync, while rst_n=0 at posedge.
  - State goes to IDLE.
  - master_read, master_write, filt_clr, filt_en, status_busy, status_done are 0.
  - master_address, master_writedata, filt_in, status_count and the internal idx/len/base registers are 0.
- Reset mid-transfer: request is dropped on that edge. No completion is waited for.
- IDLE:
  - On cmd_start=1, latch cmd_len, cmd_src_base and cmd_dst_base.
  - If len=0, go to DONE with no bus transactions.
  - Otherwise go to CLEAR.
  - Command inputs are ignored outside IDLE.
- CLEAR (1 cycle):
  - filt_clr=1, idx=0, status_count=0.
  - Next edge: master_read=1, master_address=src_base, go to READ.
- READ:
  - Hold master_read and master_address while waitrequest=1.
  - At the edge with waitrequest=0: filt_in<=master_readdata, master_read<=0, go to FEED.
- FEED (1 cycle): filt_en=1, go to CAPT.
- CAPT (1 cycle):
  - master_writedata<=filt_out, master_write<=1, master_address<=dst_base+4*idx, go to WRITE.
- WRITE:
  - Hold master_write, master_address and master_writedata while waitrequest=1.
  - At the edge with waitrequest=0: master_write<=0, status_count<=idx+1.
  - If idx=len-1, go to DONE.
  - Otherwise idx<=idx+1, master_read<=1, master_address<=src_base+4*(idx+1), go to READ.
- DONE:
  - status_done=1, status_busy=0, all requests 0.
  - Stay in DONE while cmd_start=1; go to IDLE when cmd_start=0.
  - status_count holds until the next CLEAR.
- Never assert master_read and master_write together.
- Timing: minimum 4 cycles per sample (READ, FEED, CAPT, WRITE), plus 1 cycle per waitrequest stall cycle.
- Address arithmetic:
  - base + 4*idx, computed in ADDR_W bits, wraps modulo 2^ADDR_W with no error.
  - Low 2 bits come from base; they are not forced to 0.
- filt_en and filt_clr are never high in the same cycle. filt_en pulses exactly len times per block.
- Filter latency: the result written for sample i is filt_out as seen in the cycle after the i-th filt_en pulse. The sequencer adds no further compensation.

Test Plan:
- len=4, src=0, dst=512, memory[0..3]=1,2,3,4, waitrequest=0, stub filter out=in+100:
  - reads at 0,4,8,12; writes 101,102,103,104 at 512,516,520,524.
  - done after 1+16 cycles; filt_en pulses=4, filt_clr pulses=1.
- Same block, waitrequest held high 3 cycles on the 2nd read and 2 cycles on the 3rd write:
  - address and data stable during stalls; total cycles +5; results unchanged.
- len=0 with cmd_start=1:
  - DONE next cycle, no read/write/filt_en; status_count=0.
- src_base=1016, len=3, ADDR_W=10:
  - read addresses 1016, 1020, 0 (wrap).
- Assert rst_n=0 during a stalled write of sample 2 of 4:
  - next edge master_write=0, state IDLE, all outputs 0.
  - after release with cmd_start=1, a fresh block begins from CLEAR.
- cmd_start held high after DONE:
  - remains DONE, no restart.
  - drop cmd_start -> IDLE; raise again -> second block runs with newly latched len.
